// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
//   Shared types and constants for the bit-serial arithmetic cells.
//   - state_t       : serial_subtractor sequencing states
//   - DEFAULT_WIDTH : default operand width
//   - DEFAULT_Q     : default modulus for the optional modular correction
//   - add_bit()     : one-bit full add, returns {carry, sum}
// -----------------------------------------------------------------------------
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_Q     = 12289;

    // One-bit full adder used by the serial correction pass.
    function automatic logic [1:0] add_bit(input logic x, input logic y, input logic cin);
        logic s;
        logic c;
        s = x ^ y ^ cin;
        c = (x & y) | (cin & (x ^ y));
        return {c, s};
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
//   Request/result bundle of the bit-serial subtractor.
//   master (requester): drives start, a, b; observes ready, busy, done, diff,
//                       borrow_out.
//   slave  (subtractor): the reverse.
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = serial_arith_pkg::DEFAULT_WIDTH
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  ready, busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, diff, borrow_out
    );
endinterface

// File: rtl/full_subtractor_cell.sv
// -----------------------------------------------------------------------------
// full_subtractor_cell
//   One-bit combinational full subtractor: d = x - y - bin.
//   x_i    : minuend bit
//   y_i    : subtrahend bit
//   bin_i  : borrow in
//   d_o    : difference bit
//   bout_o : borrow out
// -----------------------------------------------------------------------------
module full_subtractor_cell (
    input  logic x_i,
    input  logic y_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    assign d_o    = x_i ^ y_i ^ bin_i;
    assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);
endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor, LSB first, one bit per clock.
//   Optional feature macro: MOD_CORRECT_EN -- when defined, an underflowing
//   result gets Q added back by a second serial pass (CORR state).
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : serial_subtractor_if.slave (start/a/b in; ready/busy/done/diff/
//         borrow_out out, all outputs registered)
// Timing: accept on edge k, the result register loads on edge k+WIDTH, and the
//   done pulse is registered one edge later (k+WIDTH+1). ready is already 1 in
//   the DONE state, so a new request can be accepted back to back.
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int Q     = DEFAULT_Q
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    // Elaboration-time sanity check on the configuration.
    if (WIDTH < 2 || Q >= (2 ** WIDTH) || Q < 1) begin : g_bad_param
        $error("serial_subtractor: WIDTH must be >= 2 and 0 < Q < 2**WIDTH");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;      // subtrahend, reused as the Q shifter in CORR
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bor_q, bor_d;  // SUB borrow; kept unchanged through CORR
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             done_q, ready_q, busy_q;
    logic             d_s, bout_s;

`ifdef MOD_CORRECT_EN
    localparam logic [WIDTH-1:0] Q_VEC = WIDTH'(Q);
    logic       carry_q, carry_d;
    logic [1:0] corr_s;
    assign corr_s = add_bit(res_q[0], b_q[0], carry_q);
`endif

    full_subtractor_cell u_cell (
        .x_i    (a_q[0]),
        .y_i    (b_q[0]),
        .bin_i  (bor_q),
        .d_o    (d_s),
        .bout_o (bout_s)
    );

    // Next-state and datapath update for the serial sequencer.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        bor_d    = bor_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef MOD_CORRECT_EN
        carry_d  = carry_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    res_d   = {WIDTH{1'b0}};
                    bor_d   = 1'b0;
                    cnt_d   = {CW{1'b0}};
                    state_d = SUB;
                end else begin
                    state_d = IDLE;
                end
            end
            SUB: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {d_s, res_q[WIDTH-1:1]};
                bor_d = bout_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = {CW{1'b0}};
                    borrow_d = bout_s;
`ifdef MOD_CORRECT_EN
                    if (bout_s) begin
                        // Underflow: run a second serial pass adding Q.
                        b_d     = Q_VEC;
                        carry_d = 1'b0;
                        state_d = CORR;
                    end else begin
                        diff_d  = res_d;
                        state_d = DONE;
                    end
`else
                    diff_d  = res_d;
                    state_d = DONE;
`endif
                end else begin
                    state_d = SUB;
                end
            end
`ifdef MOD_CORRECT_EN
            CORR: begin
                res_d   = {corr_s[0], res_q[WIDTH-1:1]};
                b_d     = b_q >> 1;
                carry_d = corr_s[1];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Final carry is intentionally dropped (mod 2^WIDTH).
                    cnt_d   = {CW{1'b0}};
                    diff_d  = res_d;
                    state_d = DONE;
                end else begin
                    state_d = CORR;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            res_q    <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
            bor_q    <= 1'b0;
            diff_q   <= {WIDTH{1'b0}};
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
`ifdef MOD_CORRECT_EN
            carry_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            bor_q    <= bor_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            // done pulses for the single cycle following the DONE state.
            done_q   <= (state_q == DONE);
            ready_q  <= (state_d == IDLE) || (state_d == DONE);
            busy_q   <= (state_d == SUB) || (state_d == CORR);
`ifdef MOD_CORRECT_EN
            carry_q  <= carry_d;
`endif
        end
    end

    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Scoreboard bench: the driver pushes the expected {diff, borrow, latency}
//   of each accepted request; a monitor pops and compares on every done pulse.
//   Compile with +define+MOD_CORRECT_EN to exercise the modular build.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;
    localparam int W = 16;
    localparam int Q = 12289;
    localparam int HALF = 5;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        int           lat;
        time          t_acc;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   n_checks;
    int   n_pass;
    time  t_last_acc;
    time  t_done_seen;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W), .Q(Q)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #HALF clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the specified rules.
    function automatic exp_t model(input longint a, input longint b);
        exp_t   e;
        longint r;
        longint m;
        m = longint'(1) << W;
        r = a - b;
        e.borrow = (a < b);
        e.lat    = W + 1;
        if (r < 0) r = r + m;
`ifdef MOD_CORRECT_EN
        if (a < b) begin
            r     = (r + Q) % m;
            e.lat = 2 * W + 1;
        end
`endif
        e.diff  = W'(r);
        e.t_acc = 0;
        return e;
    endfunction

    // Issue one request; caller is at a negedge. Returns after the accept edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.ready !== 1'b1) begin
            check("ready_timeout", bus.ready, 1);
            return;
        end
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        e          = model(longint'(a), longint'(b));
        e.t_acc    = $time;
        t_last_acc = $time;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: compare every done pulse against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus.done === 1'b1) begin
            t_done_seen = $time;
            if (sb.size() == 0) begin
                check("unexpected_done", bus.done, 0);
            end else begin
                e = sb.pop_front();
                check("diff", bus.diff, e.diff);
                check("borrow_out", bus.borrow_out, e.borrow);
                check("latency", ($time - e.t_acc - HALF) / (2 * HALF), e.lat);
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("rst_diff", bus.diff, 0);
        check("rst_borrow", bus.borrow_out, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        do_op(16'd100, 16'd42);
        check("busy_after_accept", bus.busy, 1);
        drain();
        do_op(16'd5, 16'd7);
        drain();
        do_op(16'h1234, 16'h1234);
        drain();

        // start while busy is ignored.
        do_op(16'd9, 16'd4);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'd1;
        bus.b     = 16'd1;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // Reset in mid-operation.
        do_op(16'd300, 16'd1);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_diff", bus.diff, 0);
        check("midrst_borrow", bus.borrow_out, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_ready", bus.ready, 1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(16'd7, 16'd3);
        drain();

        // New request issued in the cycle done is seen.
        begin
            int n;
            do_op(16'd1, 16'd0);
            n = 0;
            while (bus.done !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("b2b_done_seen", bus.done, 1);
            do_op(16'd20, 16'd30);
            check("b2b_no_gap", t_last_acc - t_done_seen, HALF);
            drain();
        end

        // Randomized requests with random gaps (zero gap hits start-in-DONE).
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef MOD_CORRECT_EN
            if ($urandom_range(1, 0) == 1) begin
                ra = W'($urandom_range(Q - 1, 0));
                rb = W'($urandom_range(Q - 1, 0));
            end
`endif
            if (i % 7 == 0) rb = ra;
            do_op(ra, rb);
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end
        drain();
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
